// File: rtl/time_set_pkg.sv
// Shared constants for the time-set receiver: field select codes, the
// default data width and the default last-legal value of each time field.
package time_set_pkg;

  localparam int DATA_W_DEF   = 7;
  localparam int SEC_MAX_DEF  = 59;
  localparam int MIN_MAX_DEF  = 59;
  localparam int HOUR_MAX_DEF = 23;

  localparam logic [1:0] SEL_SEC  = 2'b00;
  localparam logic [1:0] SEL_MIN  = 2'b01;
  localparam logic [1:0] SEL_HOUR = 2'b10;
  localparam logic [1:0] SEL_RSVD = 2'b11;

  // True when data is a legal value for the selected field.
  function automatic logic sel_in_range(input logic [1:0] sel,
                                        input int unsigned data,
                                        input int unsigned sec_max,
                                        input int unsigned min_max,
                                        input int unsigned hour_max);
    logic ok;
    ok = 1'b0;
    case (sel)
      SEL_SEC:  ok = (data <= sec_max);
      SEL_MIN:  ok = (data <= min_max);
      SEL_HOUR: ok = (data <= hour_max);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/time_set_receiver_mod_counter.sv
// Modulo-(MAX+1) counter used for each time field. A load always beats an
// increment, and a loaded field never reports a wrap, so a write into a
// field also swallows any carry that field would have produced.
module mod_counter #(
  parameter int W   = 7,
  parameter int MAX = 59
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         wrap
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  // Wrap is combinational so every carry in the chain resolves in one edge.
  assign wrap = inc && !load && (value == MAX_V);

  // Load first, otherwise count up and roll over after MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      value <= (value == MAX_V) ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/time_set_receiver.sv
// Receiving end of the time-set bus. Detects a rising edge on set_valid,
// range-checks the write, loads the selected field and keeps time from a
// 1 Hz tick in between.
//
// Handshake: set_valid is a level from the writer. A write is taken on the
// edge where set_valid is 1 and was 0 at the previous edge; holding it high
// gives one write only. The edge after a write carries exactly one of
// set_ack (loaded) or set_err (rejected) for a single cycle; there is no
// back-pressure, the writer just watches for the pulse.
module time_set_receiver
  import time_set_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SEC_MAX  = SEC_MAX_DEF,
  parameter int MIN_MAX  = MIN_MAX_DEF,
  parameter int HOUR_MAX = HOUR_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              run,
  input  logic              set_valid,
  input  logic [1:0]        set_sel,
  input  logic [DATA_W-1:0] set_data,
  output logic              set_ack,
  output logic              set_err,
  output logic [DATA_W-1:0] sec,
  output logic [DATA_W-1:0] min,
  output logic [DATA_W-1:0] hour,
  output logic              day_wrap
);

  logic valid_q;
  logic write;
  logic legal;
  logic load_sec, load_min, load_hour;
  logic sec_wrap, min_wrap, hour_wrap;
  logic step;

  assign write = set_valid && !valid_q;
  assign legal = sel_in_range(set_sel, int'(set_data), SEC_MAX, MIN_MAX, HOUR_MAX);
  assign step  = tick && run;

  // Decode which field, if any, takes the incoming value this edge.
  always_comb begin
    load_sec  = 1'b0;
    load_min  = 1'b0;
    load_hour = 1'b0;
    if (write && legal) begin
      case (set_sel)
        SEL_SEC:  load_sec  = 1'b1;
        SEL_MIN:  load_min  = 1'b1;
        SEL_HOUR: load_hour = 1'b1;
        default:  ;
      endcase
    end
  end

  // Remember last sampled set_valid for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= set_valid;
    end
  end

  // Registered write response and end-of-day pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_ack  <= 1'b0;
      set_err  <= 1'b0;
      day_wrap <= 1'b0;
    end else begin
      set_ack  <= write && legal;
      set_err  <= write && !legal;
      day_wrap <= hour_wrap;
    end
  end

  mod_counter #(.W(DATA_W), .MAX(SEC_MAX)) u_sec (
    .clk      (clk),
    .rst      (rst),
    .inc      (step),
    .load     (load_sec),
    .load_val (set_data),
    .value    (sec),
    .wrap     (sec_wrap)
  );

  mod_counter #(.W(DATA_W), .MAX(MIN_MAX)) u_min (
    .clk      (clk),
    .rst      (rst),
    .inc      (sec_wrap),
    .load     (load_min),
    .load_val (set_data),
    .value    (min),
    .wrap     (min_wrap)
  );

  mod_counter #(.W(DATA_W), .MAX(HOUR_MAX)) u_hour (
    .clk      (clk),
    .rst      (rst),
    .inc      (min_wrap),
    .load     (load_hour),
    .load_val (set_data),
    .value    (hour),
    .wrap     (hour_wrap)
  );

endmodule

// File: tb/tb_time_set_receiver.sv
// Bench for time_set_receiver: directed scenarios followed by a random
// phase, all checked against a seconds-of-day reference model.
module tb_time_set_receiver;

  localparam int W = 7;
  localparam int EXP_W = 3 + 3 * W;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tick = 1'b0;
  logic         run = 1'b0;
  logic         set_valid = 1'b0;
  logic [1:0]   set_sel = 2'b00;
  logic [W-1:0] set_data = '0;
  logic         set_ack, set_err, day_wrap;
  logic [W-1:0] sec, min, hour;

  always #5 clk = ~clk;

  time_set_receiver dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .run       (run),
    .set_valid (set_valid),
    .set_sel   (set_sel),
    .set_data  (set_data),
    .set_ack   (set_ack),
    .set_err   (set_err),
    .sec       (sec),
    .min       (min),
    .hour      (hour),
    .day_wrap  (day_wrap)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Time is held as a count of seconds since midnight.
  int unsigned m_tod = 0;
  bit          m_prev_valid = 1'b0;

  function automatic int unsigned field_max(input int sel);
    case (sel)
      0: return 59;
      1: return 59;
      2: return 23;
      default: return 0;
    endcase
  endfunction

  task automatic model_edge(input bit tk, input bit rn, input bit vl,
                            input int sel, input int unsigned data);
    bit w, ok, ack, err, dw;
    int unsigned old_h, old_m, t, nh, nm, ns;
    w = vl && !m_prev_valid;
    m_prev_valid = vl;
    ok = (sel != 3) && (data <= field_max(sel));
    old_h = m_tod / 3600;
    old_m = (m_tod / 60) % 60;
    t = m_tod;
    dw = 1'b0;
    if (tk && rn) begin
      t = t + 1;
      if (t == 86400) begin
        t = 0;
        dw = 1'b1;
      end
    end
    nh = t / 3600;
    nm = (t / 60) % 60;
    ns = t % 60;
    if (w && ok) begin
      // A written field keeps the new value; nothing above it sees its carry.
      case (sel)
        0: begin ns = data; nm = old_m; nh = old_h; dw = 1'b0; end
        1: begin nm = data; nh = old_h; dw = 1'b0; end
        default: begin nh = data; dw = 1'b0; end
      endcase
    end
    m_tod = nh * 3600 + nm * 60 + ns;
    ack = w && ok;
    err = w && !ok;
    exp_q.push_back({ack, err, dw, W'(nh), W'(nm), W'(ns)});
  endtask

  task automatic compare_outputs();
    logic [EXP_W-1:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check("set_ack",  32'(set_ack),  32'(e[3*W+2]));
    check("set_err",  32'(set_err),  32'(e[3*W+1]));
    check("day_wrap", 32'(day_wrap), 32'(e[3*W]));
    check("hour",     32'(hour),     32'(e[3*W-1:2*W]));
    check("min",      32'(min),      32'(e[2*W-1:W]));
    check("sec",      32'(sec),      32'(e[W-1:0]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit tk, input bit rn, input bit vl,
                      input int sel, input int unsigned data);
    tick      = tk;
    run       = rn;
    set_valid = vl;
    set_sel   = 2'(sel);
    set_data  = W'(data);
    @(posedge clk);
    model_edge(tk, rn, vl, sel, data);
    #1;
    compare_outputs();
  endtask

  task automatic write_field(input int sel, input int unsigned data);
    step(1'b0, 1'b1, 1'b1, sel, data);
    step(1'b0, 1'b1, 1'b0, sel, data);
  endtask

  task automatic do_reset(input bit hold_valid);
    rst       = 1'b1;
    tick      = 1'b0;
    set_valid = hold_valid;
    set_sel   = 2'b10;
    set_data  = 7'd9;
    #2;
    m_tod = 0;
    m_prev_valid = 1'b0;
    check("rst_sec",  32'(sec),      32'd0);
    check("rst_min",  32'(min),      32'd0);
    check("rst_hour", 32'(hour),     32'd0);
    check("rst_ack",  32'(set_ack),  32'd0);
    check("rst_err",  32'(set_err),  32'd0);
    check("rst_dw",   32'(day_wrap), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    do_reset(1'b0);

    // Idle after reset.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0, 0);

    // Held set_valid gives one write.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1, 42);
    step(1'b0, 1'b1, 1'b0, 1, 42);

    // Out-of-range and reserved selects.
    write_field(0, 60);
    write_field(3, 5);
    write_field(2, 24);
    write_field(1, 59);

    // Day rollover.
    write_field(2, 23);
    write_field(1, 59);
    write_field(0, 58);
    step(1'b1, 1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 0, 0);

    // Write with simultaneous tick: minutes target, then seconds target.
    do_reset(1'b0);
    write_field(1, 5);
    write_field(0, 59);
    step(1'b1, 1'b1, 1'b1, 1, 10);
    step(1'b0, 1'b1, 1'b0, 0, 0);
    do_reset(1'b0);
    write_field(1, 5);
    write_field(0, 59);
    step(1'b1, 1'b1, 1'b1, 0, 30);
    step(1'b0, 1'b1, 1'b0, 0, 0);
    // Illegal write alongside a tick lets the tick through.
    write_field(0, 59);
    step(1'b1, 1'b1, 1'b1, 3, 1);
    step(1'b0, 1'b1, 1'b0, 0, 0);

    // Frozen time still accepts writes.
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b1, 2, 7);
    step(1'b1, 1'b0, 1'b0, 0, 0);

    // Reset while an ack is showing drops it.
    step(1'b0, 1'b1, 1'b1, 2, 8);
    do_reset(1'b0);
    step(1'b0, 1'b1, 1'b0, 0, 0);

    // set_valid already high at the first edge after reset is a write.
    do_reset(1'b1);
    step(1'b0, 1'b1, 1'b1, 2, 9);
    step(1'b0, 1'b1, 1'b0, 2, 9);

    // Random phase, periodically parked near midnight to hit rollovers.
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        write_field(2, 23);
        write_field(1, 59);
        write_field(0, $urandom_range(55, 59));
      end
      step(bit'($urandom_range(0, 2) != 0),
           bit'($urandom_range(0, 7) != 0),
           bit'($urandom_range(0, 5) == 0),
           int'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 62));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
